// File: rtl/sp_alu_pkg.sv
// Opcode map, FSM state encoding and decode helpers shared by the SPCore sequential ALU.
package sp_alu_pkg;

  localparam logic [3:0] ALU_CLEAR    = 4'h0;
  localparam logic [3:0] ALU_INC      = 4'h1;
  localparam logic [3:0] ALU_ADD      = 4'h2;
  localparam logic [3:0] ALU_MUL      = 4'h3;
  localparam logic [3:0] ALU_MAD      = 4'h4;
  localparam logic [3:0] ALU_SETP_EQ  = 4'h5;
  localparam logic [3:0] ALU_SETP_LT  = 4'h6;
  localparam logic [3:0] ALU_SETP_GT  = 4'h7;
  localparam logic [3:0] ALU_SETP_NEQ = 4'h8;
  localparam logic [3:0] ALU_CORE_ID  = 4'h9;
  localparam logic [3:0] ALU_N_CORES  = 4'hA;
  localparam logic [3:0] ALU_SUB      = 4'hB;
  localparam logic [3:0] ALU_AND      = 4'hC;
  localparam logic [3:0] ALU_OR       = 4'hD;
  localparam logic [3:0] ALU_XOR      = 4'hE;
  localparam logic [3:0] ALU_RSVD     = 4'hF;

  typedef logic [1:0] alu_state_t;
  localparam alu_state_t ST_IDLE = 2'd0;
  localparam alu_state_t ST_MUL  = 2'd1;
  localparam alu_state_t ST_DONE = 2'd2;

  function automatic logic is_setp(input logic [3:0] op);
    return (op >= ALU_SETP_EQ) && (op <= ALU_SETP_NEQ);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MAD);
  endfunction

endpackage

// File: rtl/sp_alu_mul_seq.sv
// Iterative shift-add multiplier retiring MUL_STEP bits of c per cycle, product mod 2^DATA_W.
// Latency: DATA_W/MUL_STEP steps, first step on the start edge; no backpressure (caller gates start).
module sp_alu_mul_seq #(
  parameter int DATA_W   = 16,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic              done,
  output logic [DATA_W-1:0] prod
);

  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STEPS - 1);

  logic [DATA_W-1:0] acc, b_sh, c_sh;
  logic [DATA_W-1:0] src_b, src_c, acc_base, partial;
  logic [CNT_W-1:0]  cnt, step_idx;
  logic              active, stepping;

  // The start cycle consumes the live operands so the first chunk retires on the accept edge.
  assign stepping = start || active;
  assign src_b    = start ? b : b_sh;
  assign src_c    = start ? c : c_sh;
  assign acc_base = start ? '0 : acc;
  assign step_idx = start ? '0 : cnt;
  assign partial  = src_b * DATA_W'(src_c[MUL_STEP-1:0]);
  // Asserted during the final step; prod holds the full product from the next cycle on.
  assign done     = stepping && (step_idx == LAST_IDX);
  assign prod     = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      b_sh   <= '0;
      c_sh   <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      if (stepping) begin
        acc  <= acc_base + partial;
        b_sh <= src_b << MUL_STEP;
        c_sh <= src_c >> MUL_STEP;
        cnt  <= step_idx + CNT_W'(1);
      end
      active <= stepping && !done;
    end
  end

endmodule

// File: rtl/sp_alu_seq.sv
// SPCore ALU: single-cycle ops register in 1 clk, MUL/MAD take DATA_W/MUL_STEP+1 clks.
// Backpressure: in_ready drops while the multiplier runs; in_valid during that time is dropped.
module sp_alu_seq
  import sp_alu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MUL_STEP = 2,
  parameter int CORE_ID  = 0,
  parameter int N_CORES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_c,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] alu_out,
  output logic              p,
  output logic              out_valid,
  output logic              busy
);

  if (DATA_W < 4) begin : g_chk_w
    $error("sp_alu_seq: DATA_W must be >= 4");
  end
  if (DATA_W % MUL_STEP != 0) begin : g_chk_step
    $error("sp_alu_seq: DATA_W must be a multiple of MUL_STEP");
  end

  localparam logic [DATA_W-1:0] CORE_ID_V = DATA_W'(CORE_ID);
  localparam logic [DATA_W-1:0] N_CORES_V = DATA_W'(N_CORES);

  alu_state_t        state;
  logic [DATA_W-1:0] a_lat, val_res, mul_prod;
  logic              mad_lat, setp_res, accept, mul_start, mul_done, wr_val, wr_p;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(alu_c);
  assign wr_p      = is_setp(alu_c);
  assign wr_val    = !is_setp(alu_c) && !is_mul(alu_c) && (alu_c != ALU_RSVD);

  always_comb begin
    val_res  = '0;
    setp_res = 1'b0;
    case (alu_c)
      ALU_INC:      val_res  = a + DATA_W'(1);
      ALU_ADD:      val_res  = b + c;
      ALU_SUB:      val_res  = b - c;
      ALU_AND:      val_res  = b & c;
      ALU_OR:       val_res  = b | c;
      ALU_XOR:      val_res  = b ^ c;
      ALU_CORE_ID:  val_res  = CORE_ID_V;
      ALU_N_CORES:  val_res  = N_CORES_V;
      ALU_SETP_EQ:  setp_res = (a == b);
      ALU_SETP_LT:  setp_res = (a < b);
      ALU_SETP_GT:  setp_res = (a > b);
      ALU_SETP_NEQ: setp_res = (a != b);
      default: begin
        val_res  = '0;
        setp_res = 1'b0;
      end
    endcase
  end

  sp_alu_mul_seq #(
    .DATA_W  (DATA_W),
    .MUL_STEP(MUL_STEP)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .b    (b),
    .c    (c),
    .done (mul_done),
    .prod (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_lat     <= '0;
      mad_lat   <= 1'b0;
      alu_out   <= '0;
      p         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            a_lat   <= a;
            mad_lat <= (alu_c == ALU_MAD);
            state   <= mul_done ? ST_DONE : ST_MUL;
          end else if (accept) begin
            out_valid <= 1'b1;
            if (wr_val) alu_out <= val_res;
            if (wr_p)   p       <= setp_res;
          end
        end
        ST_MUL: begin
          if (mul_done) state <= ST_DONE;
        end
        ST_DONE: begin
          alu_out   <= mad_lat ? (mul_prod + a_lat) : mul_prod;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_alu_seq.sv
// Bench for sp_alu_seq: directed vector table, multi-cycle corner sequences, random ops vs a reference model.
module tb_sp_alu_seq;
  import sp_alu_pkg::*;

  localparam int W        = 16;
  localparam int S        = 2;
  localparam int CID      = 5;
  localparam int NCORE    = 4;
  localparam int MUL_LAT  = W / S + 1;
  localparam int MUL_LAT8 = 8 / 4 + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, p, out_valid, busy;
  logic [3:0]   alu_c;
  logic [W-1:0] a, b, c, alu_out;

  logic         in_valid8, in_ready8, p8, out_valid8, busy8;
  logic [3:0]   alu_c8;
  logic [7:0]   a8, b8, c8, alu_out8;

  sp_alu_seq #(.DATA_W(W), .MUL_STEP(S), .CORE_ID(CID), .N_CORES(NCORE)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_c(alu_c),
    .a(a), .b(b), .c(c), .alu_out(alu_out), .p(p), .out_valid(out_valid), .busy(busy)
  );

  sp_alu_seq #(.DATA_W(8), .MUL_STEP(4), .CORE_ID(0), .N_CORES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .alu_c(alu_c8),
    .a(a8), .b(b8), .c(c8), .alu_out(alu_out8), .p(p8), .out_valid(out_valid8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] m_out;
  logic         m_p;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, c;
    logic [W-1:0] exp_out;
    logic         exp_p;
  } vec_t;
  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: spec rules in plain modular arithmetic.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] ma, mb, mc,
                                inout logic [W-1:0] mo, inout logic mp);
    longint unsigned va, vb, vc, md;
    va = ma; vb = mb; vc = mc; md = 64'd1 << W;
    case (op)
      4'h0: mo = '0;
      4'h1: mo = W'((va + 1) % md);
      4'h2: mo = W'((vb + vc) % md);
      4'h3: mo = W'((vb * vc) % md);
      4'h4: mo = W'((va + vb * vc) % md);
      4'h5: mp = (va == vb);
      4'h6: mp = (va < vb);
      4'h7: mp = (va > vb);
      4'h8: mp = (va != vb);
      4'h9: mo = W'(CID % md);
      4'hA: mo = W'(NCORE % md);
      4'hB: mo = W'((vb + md - vc) % md);
      4'hC: mo = mb & mc;
      4'hD: mo = mb | mc;
      4'hE: mo = mb ^ mc;
      default: ;
    endcase
  endfunction

  // Issue one op, then wait for out_valid, optionally poking in_valid while the DUT is busy.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, vb, vc, input bit garbage,
                       output int lat, output int nrdy, output int nbusy);
    in_valid = 1'b1; alu_c = op; a = va; b = vb; c = vc;
    tick();
    lat = 1; nrdy = 0; nbusy = 0;
    in_valid = 1'b0;
    while (!out_valid && lat < 30) begin
      if (!in_ready) nrdy++;
      if (busy) nbusy++;
      if (garbage && !in_ready) begin
        in_valid = lat[0];
        alu_c = 4'($urandom);
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] va, vb, vc, output int lat);
    in_valid8 = 1'b1; alu_c8 = op; a8 = va; b8 = vb; c8 = vc;
    tick();
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nrdy, nbusy, nvld;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb, rc;

    vecs[0]  = '{ALU_ADD,      16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 1'b0};
    vecs[1]  = '{ALU_INC,      16'h0005, 16'h0000, 16'h0000, 16'h0006, 1'b0};
    vecs[2]  = '{ALU_SETP_LT,  16'h0003, 16'h0004, 16'h0000, 16'h0006, 1'b1};
    vecs[3]  = '{ALU_SUB,      16'h0000, 16'h0001, 16'h0002, 16'hFFFF, 1'b1};
    vecs[4]  = '{ALU_SETP_EQ,  16'h0007, 16'h0007, 16'h0000, 16'hFFFF, 1'b1};
    vecs[5]  = '{ALU_RSVD,     16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 1'b1};
    vecs[6]  = '{ALU_SETP_GT,  16'h0002, 16'h0009, 16'h0000, 16'hFFFF, 1'b0};
    vecs[7]  = '{ALU_AND,      16'h0000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[8]  = '{ALU_OR,       16'h0000, 16'h1234, 16'h00F0, 16'h12F4, 1'b0};
    vecs[9]  = '{ALU_SETP_NEQ, 16'h0001, 16'h0002, 16'h0000, 16'h12F4, 1'b1};
    vecs[10] = '{ALU_XOR,      16'h0000, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b1};
    vecs[11] = '{ALU_CORE_ID,  16'h0000, 16'h0000, 16'h0000, 16'h0005, 1'b1};
    vecs[12] = '{ALU_N_CORES,  16'h0000, 16'h0000, 16'h0000, 16'h0004, 1'b1};
    vecs[13] = '{ALU_SETP_EQ,  16'h0003, 16'h0004, 16'h0000, 16'h0004, 1'b0};
    vecs[14] = '{ALU_CLEAR,    16'h1111, 16'h2222, 16'h3333, 16'h0000, 1'b0};
    vecs[15] = '{ALU_SETP_GT,  16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[16] = '{ALU_INC,      16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[17] = '{ALU_SETP_LT,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0};

    // Reset held with in_valid asserted must leave everything at reset values.
    rst = 1'b1; in_valid = 1'b1; alu_c = ALU_ADD; a = 16'h1; b = 16'h1; c = 16'h1;
    in_valid8 = 1'b0; alu_c8 = 4'h0; a8 = '0; b8 = '0; c8 = '0;
    repeat (3) tick();
    check("rst_alu_out", alu_out, 0);
    check("rst_p", p, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_no_valid", out_valid, 0);

    // Back-to-back single-cycle ops straight from the table.
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; alu_c = vecs[i].op; a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_alu_out", i), alu_out, vecs[i].exp_out);
      check($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    m_out = vecs[17].exp_out;
    m_p   = vecs[17].exp_p;
    tick();
    check("table_tail_no_valid", out_valid, 0);

    // MAD with in_valid pulses poked in while busy.
    issue(ALU_MAD, 16'd10, 16'd300, 16'd300, 1'b1, lat, nrdy, nbusy);
    check("mad_latency", lat, MUL_LAT);
    check("mad_in_ready_low_cycles", nrdy, MUL_LAT - 1);
    check("mad_busy_cycles", nbusy, MUL_LAT - 1);
    check("mad_alu_out", alu_out, 16'h5F9A);
    check("mad_p_held", p, m_p);
    tick();
    check("mad_single_pulse", out_valid, 0);
    check("mad_result_kept", alu_out, 16'h5F9A);
    check("mad_ready_again", in_ready, 1);

    // Reset in the middle of a multiply discards it.
    in_valid = 1'b1; alu_c = ALU_MUL; a = '0; b = 16'd3; c = 16'd5;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_alu_out", alu_out, 0);
    check("midrst_p", p, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    nvld = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) nvld++;
    end
    check("midrst_no_out_valid", nvld, 0);
    issue(ALU_ADD, 16'd0, 16'd1, 16'd1, 1'b0, lat, nrdy, nbusy);
    check("midrst_add_latency", lat, 1);
    check("midrst_add_out", alu_out, 16'd2);
    m_out = 16'd2;
    m_p   = 1'b0;

    // 8-bit, 4-bits-per-step instance.
    issue8(ALU_MUL, 8'd0, 8'd15, 8'd17, lat);
    check("w8_mul_latency", lat, MUL_LAT8);
    check("w8_mul_out", alu_out8, 8'hFF);
    issue8(ALU_MAD, 8'd1, 8'hFF, 8'hFF, lat);
    check("w8_mad_latency", lat, MUL_LAT8);
    check("w8_mad_out", alu_out8, 8'h02);
    tick();
    check("w8_single_pulse", out_valid8, 0);

    // Random ops against the model.
    for (int it = 0; it < 200; it++) begin
      rop = 4'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      if (it % 10 == 0) begin
        ra = '1;
        rb = '1;
        rc = (it % 20 == 0) ? '1 : rb;
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
        check("rand_idle_no_valid", out_valid, 0);
      end
      issue(rop, ra, rb, rc, 1'b1, lat, nrdy, nbusy);
      model(rop, ra, rb, rc, m_out, m_p);
      check($sformatf("rand%0d_op%0h_latency", it, rop), lat, is_mul(rop) ? MUL_LAT : 1);
      check($sformatf("rand%0d_op%0h_alu_out", it, rop), alu_out, m_out);
      check($sformatf("rand%0d_op%0h_p", it, rop), p, m_p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
